// File: rtl/x448_pkg.sv
// Shared constants for the Ed448-field serial modular multiplier.
// Holds the field prime, operand width, iteration count and FSM encoding.
// No logic; imported by the multiplier top and its step datapath.
package x448_pkg;

  localparam int W448 = 448;

  // 2^448 - 2^224 - 1: all ones except bit 224.
  localparam logic [W448-1:0] P448 = {{223{1'b1}}, 1'b0, {224{1'b1}}};

  // One interleaved step per multiplicand bit.
  localparam int ITER_COUNT = W448;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mulmod_step.sv
// One MSB-first interleaved modular multiply step: acc' = (2*acc + bit*yr) mod M.
// Purely combinational, zero cycles.
// No flow control; requires acc < M and yr < M, guarantees acc_nxt < M.
module mulmod_step
  import x448_pkg::*;
#(
  parameter int N = W448
) (
  input  logic [N-1:0] acc,
  input  logic         xbit,
  input  logic [N-1:0] yr,
  input  logic [N-1:0] M,
  output logic [N-1:0] acc_nxt
);

  logic [N:0] m_ext;
  logic [N:0] t;
  logic [N:0] u;

  // Doubling then conditional add, each followed by a single conditional
  // subtract; N+1 bits holds both 2*acc and t+yr since both stay below 2M.
  always_comb begin
    m_ext = {1'b0, M};
    t     = {acc, 1'b0};
    if (t >= m_ext) t = t - m_ext;
    u = t + (xbit ? {1'b0, yr} : {(N+1){1'b0}});
    if (u >= m_ext) u = u - m_ext;
    acc_nxt = u[N-1:0];
  end

endmodule

// File: rtl/mulmod_serial.sv
// Bit-serial modular multiplier: Z = (X*Y) mod M, one multiplicand bit per cycle.
// Latency: res_valid rises N edges after the edge that raised req_ready.
// Accepts a request only in IDLE; holds the result until res_ready in DONE.
module mulmod_serial
  import x448_pkg::*;
#(
  parameter int          N = W448,
  parameter logic [N-1:0] M = P448
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  output logic [N-1:0] Z,
  input  logic         req_valid,
  output logic         req_ready,
  output logic         req_busy,
  output logic         res_valid,
  input  logic         res_ready
);

  localparam int CW = $clog2(N);

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   acc;
  logic [N-1:0]   xr;
  logic [N-1:0]   yr;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   acc_nxt;
  logic [N-1:0]   y_red;
  logic           capture;
  logic           step_en;
  logic           finish;
  logic           release_res;

  // Any N-bit Y is below 2M, so one conditional subtract fully reduces it.
  assign y_red = (Y >= M) ? (Y - M) : Y;

  mulmod_step #(.N(N)) u_step (
    .acc     (acc),
    .xbit    (xr[N-1]),
    .yr      (yr),
    .M       (M),
    .acc_nxt (acc_nxt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and control strobes; requests in ITER/DONE are ignored and a
  // release in DONE never doubles as an acceptance.
  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    step_en     = 1'b0;
    finish      = 1'b0;
    release_res = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          capture   = 1'b1;
          state_nxt = ITER;
        end
      end
      ITER: begin
        step_en = 1'b1;
        if (cnt == '0) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          release_res = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath, result register and handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      xr        <= '0;
      yr        <= '0;
      cnt       <= '0;
      Z         <= '0;
      req_ready <= 1'b0;
      req_busy  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      req_ready <= capture;
      if (capture) begin
        xr       <= X;
        yr       <= y_red;
        acc      <= '0;
        cnt      <= CW'(N - 1);
        req_busy <= 1'b1;
      end
      if (step_en) begin
        acc <= acc_nxt;
        xr  <= {xr[N-2:0], 1'b0};
        if (!finish) cnt <= cnt - CW'(1);
      end
      if (finish) begin
        Z         <= acc_nxt;
        res_valid <= 1'b1;
        req_busy  <= 1'b0;
      end
      if (release_res) res_valid <= 1'b0;
    end
  end

endmodule
